// File: rtl/led_controller.sv
// Purpose: shared blink timebase, power-on lamp-test walk and LED output mux
//          (driver pass-through / lamp test / identify blink) for all ports.
// Ports:   clk, rst (async, active-high); drv_led[2*NUM_PORTS] from per-port
//          drivers; identify (level); lamp_test_req (pulse); blink (timebase
//          to drivers); led[2*NUM_PORTS] to pins; lamp_test_active.
module led_controller #(
    parameter int NUM_PORTS = 4,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NUM_PORTS-1:0] drv_led,
    input  logic                   identify,
    input  logic                   lamp_test_req,
    output logic                   blink,
    output logic [2*NUM_PORTS-1:0] led,
    output logic                   lamp_test_active
);

    localparam int CNT_W  = $clog2(BLINK_DIV);
    localparam int STEP_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int LED_W  = 2 * NUM_PORTS;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLINK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_LAMP_TEST = 2'd0,
        ST_NORMAL    = 2'd1,
        ST_IDENTIFY  = 2'd2
    } state_t;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_blink;
    logic [LED_W-1:0]  r_led;
    state_t            r_state;
    logic [STEP_W-1:0] r_step;

    logic              w_tick;
    state_t            w_state_nxt;
    logic [STEP_W-1:0] w_step_nxt;
    logic [LED_W-1:0]  w_led_nxt;
    logic              w_lamp_active;

    // ------------------------------------------------------------------
    // Prescaler: free-running in every state, untouched by lamp_test_req
    // so the blink cadence seen by the drivers never jitters.
    // ------------------------------------------------------------------
    assign w_tick = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_blink <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LAMP_TEST;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        case (r_state)
            ST_LAMP_TEST: begin
                // A new request restarts the walk; the walk advances only on
                // prescaler ticks, so a mid-period restart shortens slot 0.
                if (lamp_test_req) begin
                    w_step_nxt = '0;
                end else if (w_tick) begin
                    if (r_step == STEP_LAST) begin
                        w_state_nxt = ST_NORMAL;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt = r_step + STEP_W'(1);
                    end
                end
            end
            ST_NORMAL: begin
                if (lamp_test_req) begin
                    w_state_nxt = ST_LAMP_TEST;
                    w_step_nxt  = '0;
                end else if (identify) begin
                    w_state_nxt = ST_IDENTIFY;
                end
            end
            ST_IDENTIFY: begin
                if (lamp_test_req) begin
                    w_state_nxt = ST_LAMP_TEST;
                    w_step_nxt  = '0;
                end else if (!identify) begin
                    w_state_nxt = ST_NORMAL;
                end
            end
            default: begin
                w_state_nxt = ST_LAMP_TEST;
                w_step_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The LED pattern is built from the current (pre-edge)
    // state/step/blink and registered, giving one cycle of latency.
    // ------------------------------------------------------------------
    always_comb begin
        w_led_nxt     = '0;
        w_lamp_active = (r_state == ST_LAMP_TEST);
        case (r_state)
            ST_LAMP_TEST: begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    w_led_nxt[2*p +: 2] = (r_step == STEP_W'(p)) ? 2'b11 : 2'b00;
                end
            end
            ST_NORMAL:   w_led_nxt = drv_led;
            ST_IDENTIFY: w_led_nxt = {LED_W{r_blink}};
            default:     w_led_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    assign blink            = r_blink;
    assign led              = r_led;
    assign lamp_test_active = w_lamp_active;

endmodule

// File: tb/tb_led_controller.sv
// Purpose: scoreboard bench for led_controller with an edge-counting reference
//          model; directed scenarios followed by randomized traffic.
// Ports:   none (top-level bench).
module tb_led_controller;

    localparam int NP = 4;
    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] drv_led = 8'hA5;
    logic       identify = 1'b0;
    logic       lamp_test_req = 1'b0;
    logic       blink;
    logic [7:0] led;
    logic       lamp_test_active;

    always #5 clk = ~clk;

    led_controller #(.NUM_PORTS(NP), .BLINK_DIV(BD)) dut (
        .clk              (clk),
        .rst              (rst),
        .drv_led          (drv_led),
        .identify         (identify),
        .lamp_test_req    (lamp_test_req),
        .blink            (blink),
        .led              (led),
        .lamp_test_active (lamp_test_active)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] led;
        logic       blink;
        logic       lta;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Time is counted in edges since reset release:
    // blink after k edges is bit 0 of k/BD, a tick happens on the edge that
    // completes each BD-cycle period. Mode: 0 lamp test, 1 normal, 2 identify.
    // ------------------------------------------------------------------
    int   m_n    = 0;
    int   m_mode = 0;
    int   m_port = 0;
    exp_t m_e;
    logic m_pre_blink;
    logic m_tick;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_n    = 0;
                m_mode = 0;
                m_port = 0;
                sb_q.delete();
            end else begin
                m_pre_blink = ((m_n / BD) % 2) == 1;
                m_tick      = (m_n % BD) == BD - 1;
                if (m_mode == 0)      m_e.led = 8'h03 << (2 * m_port);
                else if (m_mode == 1) m_e.led = drv_led;
                else                  m_e.led = m_pre_blink ? 8'hFF : 8'h00;
                if (m_mode == 0) begin
                    if (lamp_test_req) m_port = 0;
                    else if (m_tick) begin
                        if (m_port == NP - 1) begin
                            m_mode = 1;
                            m_port = 0;
                        end else begin
                            m_port = m_port + 1;
                        end
                    end
                end else if (lamp_test_req) begin
                    m_mode = 0;
                    m_port = 0;
                end else if (m_mode == 1 && identify) begin
                    m_mode = 2;
                end else if (m_mode == 2 && !identify) begin
                    m_mode = 1;
                end
                m_n       = m_n + 1;
                m_e.blink = ((m_n / BD) % 2) == 1;
                m_e.lta   = (m_mode == 0);
                sb_q.push_back(m_e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: the DUT presents a fresh output every cycle outside reset.
    // ------------------------------------------------------------------
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty no expected entry t=%0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (led !== mon_e.led || blink !== mon_e.blink ||
                        lamp_test_active !== mon_e.lta) begin
                        errors++;
                        $display("FAIL sb t=%0t led=%h exp=%h blink=%b exp=%b lta=%b exp=%b",
                                 $time, led, mon_e.led, blink, mon_e.blink,
                                 lamp_test_active, mon_e.lta);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req;
        lamp_test_req = 1'b1;
        @(negedge clk);
        lamp_test_req = 1'b0;
    endtask

    logic [7:0] led_tab [0:17];
    logic       found;

    initial begin
        for (int k = 0; k <= 17; k++) begin
            if (k == 0)       led_tab[k] = 8'h00;
            else if (k <= 16) led_tab[k] = 8'h03 << (2 * ((k - 1) / 4));
            else              led_tab[k] = 8'hA5;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_led", 32'(led), 32'h00);
        chk("rst_blink", 32'(blink), 32'h0);
        chk("rst_lta", 32'(lamp_test_active), 32'h1);
        rst = 1'b0;

        // Power-on lamp test, edge by edge
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #2;
            chk($sformatf("lamp_led_e%0d", k), 32'(led), 32'(led_tab[k]));
            if (k == 3)  chk("blink_e3", 32'(blink), 32'h0);
            if (k == 4)  chk("blink_e4", 32'(blink), 32'h1);
            if (k == 15) chk("lta_e15", 32'(lamp_test_active), 32'h1);
            if (k == 16) chk("lta_e16", 32'(lamp_test_active), 32'h0);
        end
        @(negedge clk);

        // Passthrough
        drv_led = 8'h5A;
        cycles(16);

        // Identify on, then off
        identify = 1'b1;
        cycles(14);
        identify = 1'b0;
        cycles(6);

        // Priority: lamp_test_req beats identify, identify held through walk
        identify = 1'b1;
        pulse_req();
        cycles(22);
        identify = 1'b0;
        cycles(4);

        // Mid-half-period request at cnt == 1
        found = 1'b0;
        for (int i = 0; i < 2 * BD && !found; i++) begin
            if ((m_n % BD) == 1) found = 1'b1;
            else @(negedge clk);
        end
        chk("mid_req_phase_found", 32'(found), 32'h1);
        pulse_req();
        cycles(20);

        // Async reset while identifying with blink high
        identify = 1'b1;
        cycles(4);
        found = 1'b0;
        for (int i = 0; i < 4 * BD && !found; i++) begin
            @(negedge clk);
            if (m_mode == 2 && ((m_n / BD) % 2) == 1) found = 1'b1;
        end
        chk("arst_setup_found", 32'(found), 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_led", 32'(led), 32'h00);
        chk("arst_blink", 32'(blink), 32'h0);
        chk("arst_lta", 32'(lamp_test_active), 32'h1);
        #1 rst = 1'b0;
        @(negedge clk);
        cycles(20);
        identify = 1'b0;
        cycles(4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drv_led = 8'($urandom);
            if ($urandom_range(0, 15) == 0) identify = ~identify;
            lamp_test_req = ($urandom_range(0, 29) == 0);
            @(negedge clk);
        end
        lamp_test_req = 1'b0;
        cycles(2);

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
